// File: rtl/matmul_pkg.sv
// Shared FSM state type and size-check helpers for the matrix loader.
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SIZE,
        LOAD_A,
        LOAD_B,
        DONE
    } state_e;

    localparam int         IDX_W    = 4;
    localparam logic [7:0] SIZE_MIN = 8'd1;

    function automatic logic size_ok(input logic [7:0] size_byte, input logic [7:0] max_n);
        return (size_byte >= SIZE_MIN) && (size_byte <= max_n);
    endfunction

endpackage

// File: rtl/mat_index_counter.sv
// Row/column element counter for an N x N matrix, row-major order.
// Wraps the column at N-1, flags the last element and clears itself after it.
module mat_index_counter
    import matmul_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [IDX_W-1:0] n,
    output logic [IDX_W-1:0] row,
    output logic [IDX_W-1:0] col,
    output logic             last
);

    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic             col_wrap;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        row_d    = row_q;
        col_d    = col_q;
        col_wrap = (col_q == n - IDX_W'(1));
        last     = col_wrap && (row_q == n - IDX_W'(1));
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (inc) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = last ? '0 : row_q + IDX_W'(1);
            end else begin
                col_d = col_q + IDX_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row = row_q;
    assign col = col_q;

endmodule

// File: rtl/matrix_loader.sv
// Loads two N x N byte matrices (A then B) from a UART byte stream into memory.
// Define MATRIX_LOADER_TRANSPOSE_B_EN to store B column-major.
module matrix_loader
    import matmul_pkg::*;
#(
    parameter int MAX_N  = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_enable,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic [3:0]        matrix_size,
    output logic              busy,
    output logic              load_done,
    output logic              size_err
);

    state_e            state_q, state_d;
    logic [3:0]        matrix_size_q, matrix_size_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_sel_q, mem_sel_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              size_err_q, size_err_d;

    logic              loading, elem_accept, size_accept, size_reject, cnt_clr, last_elem;
    logic [IDX_W-1:0]  row, col;
    logic [ADDR_W-1:0] addr_a, addr_b;

    assign loading     = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign elem_accept = loading && rx_valid && !abort;
    assign size_accept = (state_q == SIZE) && rx_valid && !abort && size_ok(rx_data, 8'(MAX_N));
    assign size_reject = (state_q == SIZE) && rx_valid && !abort && !size_ok(rx_data, 8'(MAX_N));
    assign cnt_clr     = abort || !loading;

    mat_index_counter u_idx (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (elem_accept),
        .n     (matrix_size_q),
        .row   (row),
        .col   (col),
        .last  (last_elem)
    );

    // Index products stay below MAX_N*MAX_N, so ADDR_W holds them without overflow.
    assign addr_a = ADDR_W'(row) * ADDR_W'(matrix_size_q) + ADDR_W'(col);
`ifdef MATRIX_LOADER_TRANSPOSE_B_EN
    assign addr_b = ADDR_W'(col) * ADDR_W'(matrix_size_q) + ADDR_W'(row);
`else
    assign addr_b = addr_a;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort && state_q != DONE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start)                    state_d = SIZE;
                SIZE:    if (size_accept)              state_d = LOAD_A;
                         else if (size_reject)         state_d = IDLE;
                LOAD_A:  if (elem_accept && last_elem) state_d = LOAD_B;
                LOAD_B:  if (elem_accept && last_elem) state_d = DONE;
                DONE:                                  state_d = IDLE;
                default:                               state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rx_enable = (state_q == SIZE) || loading;
        busy      = (state_q != IDLE);
        load_done = (state_q == DONE);
    end

    // Write port is registered: the write for a byte appears the cycle after its strobe.
    always_comb begin
        mem_we_d      = elem_accept;
        mem_sel_d     = mem_sel_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        size_err_d    = size_reject;
        matrix_size_d = matrix_size_q;
        if (elem_accept) begin
            mem_sel_d   = (state_q == LOAD_B);
            mem_addr_d  = (state_q == LOAD_B) ? addr_b : addr_a;
            mem_wdata_d = rx_data;
        end
        if (size_accept) matrix_size_d = rx_data[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            matrix_size_q <= '0;
            mem_we_q      <= 1'b0;
            mem_sel_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            size_err_q    <= 1'b0;
        end else begin
            matrix_size_q <= matrix_size_d;
            mem_we_q      <= mem_we_d;
            mem_sel_q     <= mem_sel_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            size_err_q    <= size_err_d;
        end
    end

    assign matrix_size = matrix_size_q;
    assign mem_we      = mem_we_q;
    assign mem_sel     = mem_sel_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign size_err    = size_err_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: stimulus pushes expected writes/errors,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_matrix_loader;

    localparam int MAX_N  = 8;
    localparam int ADDR_W = 6;
`ifdef MATRIX_LOADER_TRANSPOSE_B_EN
    localparam bit TRANSPOSE_B = 1'b1;
`else
    localparam bit TRANSPOSE_B = 1'b0;
`endif

    typedef struct {
        bit is_err;
        bit sel;
        int addr;
        int data;
        bit done;
    } exp_t;

    typedef logic [7:0] byte_q_t[$];

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   last_size = 0;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              start    = 1'b0;
    logic              abort    = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data  = 8'h00;
    logic              rx_enable, mem_we, mem_sel, busy, load_done, size_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [3:0]        matrix_size;

    matrix_loader #(.MAX_N(MAX_N), .ADDR_W(ADDR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_enable   (rx_enable),
        .mem_we      (mem_we),
        .mem_sel     (mem_sel),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .matrix_size (matrix_size),
        .busy        (busy),
        .load_done   (load_done),
        .size_err    (size_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected address from the storage rules: A row-major, B row- or column-major.
    function automatic int model_addr(input int n, input int k);
        int idx = k % (n * n);
        int r   = idx / n;
        int c   = idx % n;
        if (k >= n * n && TRANSPOSE_B) return c * n + r;
        return r * n + c;
    endfunction

    function automatic logic [31:0] all_outputs();
        return 32'({rx_enable, mem_we, mem_sel, mem_addr, mem_wdata, matrix_size, busy, load_done, size_err});
    endfunction

    always @(negedge clk) begin
        if (rst_n && (mem_we || size_err || load_done)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 32'({mem_we, size_err, load_done}), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_err) begin
                    check("size_err_pulse", 32'(size_err), 32'd1);
                    check("size_err_no_we", 32'(mem_we), 32'd0);
                    check("size_err_no_done", 32'(load_done), 32'd0);
                end else begin
                    check("write_we", 32'(mem_we), 32'd1);
                    check("write_sel", 32'(mem_sel), 32'(mon_e.sel));
                    check("write_addr", 32'(mem_addr), 32'(mon_e.addr));
                    check("write_data", 32'(mem_wdata), 32'(mon_e.data));
                    check("write_load_done", 32'(load_done), 32'(mon_e.done));
                    check("write_no_size_err", 32'(size_err), 32'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_write(input int n, input int k, input logic [7:0] b, input bit done);
        exp_q.push_back('{is_err: 1'b0, sel: (k >= n * n), addr: model_addr(n, k), data: int'(b), done: done});
    endtask

    task automatic rand_bytes(input int cnt, output byte_q_t q);
        q = {};
        for (int i = 0; i < cnt; i++) q.push_back(8'($urandom));
    endtask

    task automatic do_load(input int n, input byte_q_t bytes, input int max_gap, input bit poke_start);
        int total = 2 * n * n;
        pulse_start();
        check("rx_enable_in_size", 32'(rx_enable), 32'd1);
        check("busy_in_size", 32'(busy), 32'd1);
        drive_byte(8'(n), int'($urandom_range(0, max_gap)));
        check("matrix_size_latched", 32'(matrix_size), 32'(n));
        last_size = n;
        for (int k = 0; k < total; k++) begin
            push_write(n, k, bytes[k], k == total - 1);
            if (poke_start && k == total / 2 && k != total - 1) start = 1'b1;
            drive_byte(bytes[k], (k == total - 1) ? 0 : int'($urandom_range(0, max_gap)));
            start = 1'b0;
        end
        check("busy_in_done", 32'(busy), 32'd1);
        tick();
        check("busy_after_done", 32'(busy), 32'd0);
        check("rx_enable_after_done", 32'(rx_enable), 32'd0);
    endtask

    task automatic bad_size(input logic [7:0] b);
        pulse_start();
        exp_q.push_back('{is_err: 1'b1, sel: 1'b0, addr: 0, data: 0, done: 1'b0});
        drive_byte(b, 0);
        check("busy_after_size_err", 32'(busy), 32'd0);
        check("size_kept_after_err", 32'(matrix_size), 32'(last_size));
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        byte_q_t bytes;

        #12;
        check("reset_outputs_zero", all_outputs(), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        drive_byte(8'h55, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("idle_ignores_rx", 32'(busy), 32'd0);

        bytes = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        do_load(2, bytes, 0, 1'b0);

        bad_size(8'd0);
        bad_size(8'(MAX_N + 1));

        bytes = {8'hAA, 8'hBB};
        do_load(1, bytes, 0, 1'b0);

        rand_bytes(2 * MAX_N * MAX_N, bytes);
        do_load(MAX_N, bytes, 0, 1'b1);

        for (int i = 0; i < 4; i++) begin
            int n = int'($urandom_range(1, MAX_N));
            rand_bytes(2 * n * n, bytes);
            do_load(n, bytes, 2, i[0]);
        end

        // Abort coinciding with the fifth A byte of a 3x3 load.
        pulse_start();
        drive_byte(8'd3, 0);
        last_size = 3;
        for (int k = 0; k < 4; k++) begin
            push_write(3, k, 8'(8'h30 + k), 1'b0);
            drive_byte(8'(8'h30 + k), 0);
        end
        rx_valid = 1'b1;
        rx_data  = 8'hEE;
        abort    = 1'b1;
        tick();
        rx_valid = 1'b0;
        abort    = 1'b0;
        check("busy_after_abort", 32'(busy), 32'd0);
        check("rx_enable_after_abort", 32'(rx_enable), 32'd0);
        repeat (3) tick();
        check("abort_writes_drained", 32'(exp_q.size()), 32'd0);

        // Reset while loading B, then a clean load.
        pulse_start();
        drive_byte(8'd2, 0);
        for (int k = 0; k < 6; k++) begin
            push_write(2, k, 8'(8'h60 + k), 1'b0);
            drive_byte(8'(8'h60 + k), 0);
        end
        repeat (2) tick();
        check("rx_enable_in_load_b", 32'(rx_enable), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_load_reset_outputs_zero", all_outputs(), 32'd0);
        check("mid_load_reset_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) tick();
        rst_n     = 1'b1;
        last_size = 0;
        tick();
        rand_bytes(8, bytes);
        do_load(2, bytes, 1, 1'b0);

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
